// File: rtl/log2_pkg.sv
// Shared types and helpers for the log2 search block and its get_pow relatives.
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  // Result width able to hold a ceil result equal to w itself.
  function automatic int pow_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/log2_seq_if.sv
// Producer/consumer handshake bundle for log2_seq: operand in, exponent and flags out.
interface log2_seq_if #(
  parameter int WIDTH = 8
);
  import log2_pkg::*;

  localparam int POW_W = pow_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] number;
  logic             ceil_mode;
  logic             out_valid;
  logic             out_ready;
  logic [POW_W-1:0] pow;
  logic             zero;
  logic             exact;

  modport master (
    output in_valid, number, ceil_mode, out_ready,
    input  in_ready, out_valid, pow, zero, exact
  );

  modport slave (
    input  in_valid, number, ceil_mode, out_ready,
    output in_ready, out_valid, pow, zero, exact
  );
endinterface

// File: rtl/log2_step.sv
// One binary-search step: keep the candidate bit if the operand still has
// a set bit at or above that position.
module log2_step #(
  parameter int WIDTH = 8,
  parameter int LOG_W = 3
) (
  input  logic [WIDTH-1:0] number,
  input  logic [LOG_W-1:0] acc,
  input  logic [LOG_W-1:0] step,
  output logic [LOG_W-1:0] acc_next
);

  logic [LOG_W-1:0] cand;

  // Shift amounts at or beyond WIDTH naturally produce zero, rejecting the candidate.
  assign cand     = acc | (LOG_W'(1) << step);
  assign acc_next = ((number >> cand) != '0) ? cand : acc;

endmodule

// File: rtl/log2_seq.sv
// Sequential floor/ceil log2 with zero and power-of-two flags, found by a
// binary search over bit positions, one step per clock.
module log2_seq
  import log2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  log2_seq_if.slave bus
);

  localparam int LOG_W = $clog2(WIDTH);
  localparam int POW_W = pow_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] number_reg;
  logic             ceil_reg;
  logic [LOG_W-1:0] acc, acc_next, step;
  logic [POW_W-1:0] pow_reg, pow_calc;
  logic             zero_reg, exact_reg, exact_calc;

  log2_step #(
    .WIDTH(WIDTH),
    .LOG_W(LOG_W)
  ) u_step (
    .number  (number_reg),
    .acc     (acc),
    .step    (step),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = (bus.number == '0) ? DONE : SEARCH;
      SEARCH:  if (step == '0) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final result uses the accumulator value produced by the last step.
  always_comb begin
    exact_calc = ((number_reg & (number_reg - WIDTH'(1))) == '0);
    pow_calc   = POW_W'(acc_next);
    if (ceil_reg && !exact_calc) pow_calc = POW_W'(acc_next) + POW_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number_reg <= '0;
      ceil_reg   <= 1'b0;
      acc        <= '0;
      step       <= '0;
      pow_reg    <= '0;
      zero_reg   <= 1'b0;
      exact_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            number_reg <= bus.number;
            ceil_reg   <= bus.ceil_mode;
            acc        <= '0;
            step       <= LOG_W'(LOG_W - 1);
            if (bus.number == '0) begin
              pow_reg   <= '0;
              zero_reg  <= 1'b1;
              exact_reg <= 1'b0;
            end
          end
        end
        SEARCH: begin
          acc  <= acc_next;
          step <= step - LOG_W'(1);
          if (step == '0) begin
            pow_reg   <= pow_calc;
            zero_reg  <= 1'b0;
            exact_reg <= exact_calc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.pow       = pow_reg;
  assign bus.zero      = zero_reg;
  assign bus.exact     = exact_reg;

endmodule

// File: tb/tb_log2_seq.sv
// Randomised and directed bench for log2_seq at WIDTH=8 and WIDTH=32 against
// a bit-scan reference model.
module tb_log2_seq;

  localparam int LOG8  = 3;
  localparam int LOG32 = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int check_count = 0;
  int pass_count  = 0;
  int rmode       = 0;
  logic mon_en    = 1'b0;

  // Monitor's view of the single transaction in flight on the 8-bit DUT.
  bit busy       = 1'b0;
  int since      = 0;
  int lat_req    = 0;
  int exp_pow    = 0;
  bit exp_zero   = 1'b0;
  bit exp_exact  = 1'b0;

  log2_seq_if #(.WIDTH(8))  bus8 ();
  log2_seq_if #(.WIDTH(32)) bus32 ();

  log2_seq #(.WIDTH(8)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.slave)
  );

  log2_seq #(.WIDTH(32)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Highest set bit by scan; power of two by popcount.
  function automatic void refModel(input logic [31:0] n, input bit c,
                                   output int p, output bit z, output bit e);
    int fl;
    fl = 0;
    for (int i = 0; i < 32; i++) if (n[i]) fl = i;
    z = (n == 0);
    e = (n != 0) && ($countones(n) == 1);
    p = z ? 0 : fl + ((c && !e) ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       bus8.out_ready = 1'b1;
      1:       bus8.out_ready = 1'($urandom_range(0, 1));
      default: bus8.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    bit exp_ov;
    if (rst) begin
      busy = 1'b0;
    end else if (mon_en) begin
      if (busy) since++;
      exp_ov = busy && (since >= lat_req);
      checkOutput("in_ready", bus8.in_ready, !busy);
      checkOutput("out_valid", bus8.out_valid, exp_ov);
      if (exp_ov) begin
        checkOutput("pow", bus8.pow, exp_pow);
        checkOutput("zero", bus8.zero, exp_zero);
        checkOutput("exact", bus8.exact, exp_exact);
      end
      if (exp_ov && bus8.out_ready) begin
        busy = 1'b0;
      end else if (!busy && bus8.in_valid) begin
        refModel({24'd0, bus8.number}, bus8.ceil_mode, exp_pow, exp_zero, exp_exact);
        busy    = 1'b1;
        since   = 0;
        lat_req = exp_zero ? 1 : LOG8 + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] n, input bit c);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #2;
    bus8.in_valid  = 1'b1;
    bus8.number    = n;
    bus8.ceil_mode = c;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus8.in_ready) done = 1'b1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    bus8.in_valid  = 1'b0;
    bus8.number    = 8'($urandom);
    bus8.ceil_mode = 1'($urandom);
  endtask

  task automatic waitResult8(output int p, output bit z, output bit e);
    bit done;
    done = 1'b0;
    p = -1; z = 1'b0; e = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus8.out_valid) begin
        done = 1'b1;
        p = int'(bus8.pow); z = bus8.zero; e = bus8.exact;
      end
    end
    if (!done) checkOutput("result_timeout", 0, 1);
  endtask

  task automatic op32(input logic [31:0] n, input bit c, output int p, output bit e);
    int cyc;
    bit done;
    done = 1'b0;
    cyc  = 0;
    p = -1; e = 1'b0;
    @(negedge clk);
    bus32.in_valid  = 1'b1;
    bus32.number    = n;
    bus32.ceil_mode = c;
    @(posedge clk);
    #2;
    bus32.in_valid = 1'b0;
    bus32.number   = $urandom;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (bus32.out_valid) begin
        done = 1'b1;
        p = int'(bus32.pow); e = bus32.exact;
      end
    end
    checkOutput("lat32", cyc, (n == 0) ? 1 : LOG32 + 1);
  endtask

  initial begin
    int p, rp;
    bit z, e, rz, re;
    bus8.in_valid  = 1'b0; bus8.number  = '0; bus8.ceil_mode  = 1'b0; bus8.out_ready  = 1'b1;
    bus32.in_valid = 1'b0; bus32.number = '0; bus32.ceil_mode = 1'b0; bus32.out_ready = 1'b1;

    // Pin the reference model with hand-computed values.
    refModel(32'h5A, 1'b0, rp, rz, re);        checkOutput("model_5a_floor", rp, 6);
    refModel(32'h5A, 1'b1, rp, rz, re);        checkOutput("model_5a_ceil", rp, 7);
    refModel(32'h80000001, 1'b1, rp, rz, re);  checkOutput("model_32_ceil", rp, 32);
    refModel(32'h0, 1'b1, rp, rz, re);         checkOutput("model_zero", {rz, re}, 2'b10);

    #1 rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", bus8.in_ready, 1);
    checkOutput("rst_out_valid", bus8.out_valid, 0);
    checkOutput("rst_pow", bus8.pow, 0);
    checkOutput("rst_flags", {bus8.zero, bus8.exact}, 2'b00);
    @(negedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    applyStimulus(8'h40, 1'b0); waitResult8(p, z, e);
    checkOutput("d40_pow", p, 6); checkOutput("d40_flags", {z, e}, 2'b01);
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h01, 1'b1); waitResult8(p, z, e);
    checkOutput("d01_pow", p, 0); checkOutput("d01_exact", e, 1);
    applyStimulus(8'h5A, 1'b0); waitResult8(p, z, e); checkOutput("d5a_floor", p, 6);
    applyStimulus(8'h5A, 1'b1); waitResult8(p, z, e); checkOutput("d5a_ceil", p, 7);
    applyStimulus(8'h81, 1'b1); waitResult8(p, z, e); checkOutput("d81_ceil", p, 8);
    applyStimulus(8'h00, 1'b1); waitResult8(p, z, e);
    checkOutput("dzero_pow", p, 0); checkOutput("dzero_flags", {z, e}, 2'b10);

    op32(32'h80000001, 1'b1, p, e); checkOutput("w32_ceil", p, 32);
    op32(32'h80000000, 1'b1, p, e); checkOutput("w32_exact_pow", p, 31); checkOutput("w32_exact", e, 1);
    op32(32'h00012345, 1'b0, p, e); refModel(32'h00012345, 1'b0, rp, rz, re); checkOutput("w32_mid", p, rp);

    // Backpressure, then a reset that aborts a search in progress.
    rmode = 2;
    applyStimulus(8'h40, 1'b0); waitResult8(p, z, e);
    repeat (5) @(negedge clk);
    checkOutput("bp_valid", bus8.out_valid, 1);
    checkOutput("bp_pow", bus8.pow, 6);
    rmode = 0;
    applyStimulus(8'h33, 1'b1);
    @(negedge clk); #1 rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", bus8.in_ready, 1);
    checkOutput("abort_out_valid", bus8.out_valid, 0);
    @(negedge clk); #1 rst = 1'b0;
    applyStimulus(8'h80, 1'b0); waitResult8(p, z, e); checkOutput("post_rst_pow", p, 7);

    rmode = 1;
    for (int k = 0; k < 150; k++) begin
      logic [7:0] n;
      int sh;
      sh = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0:       n = 8'($urandom);
        1:       n = 8'd0;
        2:       n = 8'(1 << sh);
        default: n = 8'((1 << sh) + 1);
      endcase
      applyStimulus(n, 1'($urandom));
    end
    rmode = 0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    checkOutput("drain", busy, 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
